// File: rtl/de_mux14_pkg.sv
// Shared constants, select encoding and decode helper for the de_mux14
// registered 1-to-4 demultiplexer.
package de_mux14_pkg;

  localparam int NUM_OUT = 4;
  localparam int SEL_W   = 2;
  localparam int CNT_W   = 16;

  // Select index {s1,s0}; the value names the output it routes to.
  typedef enum logic [SEL_W-1:0] {
    SEL_OP0 = 2'd0,
    SEL_OP1 = 2'd1,
    SEL_OP2 = 2'd2,
    SEL_OP3 = 2'd3
  } sel_e;

  // One-hot decode of a select index into a per-output hit vector.
  function automatic logic [NUM_OUT-1:0] sel_onehot(input sel_e sel);
    return NUM_OUT'(1) << sel;
  endfunction

endpackage

// File: rtl/de_mux14_chan.sv
// One output slice of de_mux14: data register, valid flop, hold/zero policy
// for unselected cycles and, when DEMUX14_CNT_EN is defined, a saturating
// hit counter with synchronous clear.
module de_mux14_chan
  import de_mux14_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int HOLD_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic              hit,
`ifdef DEMUX14_CNT_EN
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt,
`endif
  output logic [DATA_W-1:0] q,
  output logic              q_valid
);

  logic [DATA_W-1:0] r_data;
  logic              r_valid;

  // Data register: load on hit, otherwise zero or hold depending on HOLD_MODE.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous and is tested first, so it wins over a hit
    // arriving in the same cycle; non-blocking (<=) keeps every flop sampling
    // pre-edge values regardless of statement order.
    if (rst) begin
      r_data <= '0;
    end else if (hit) begin
      r_data <= in;
    end else if (HOLD_MODE == 0) begin
      r_data <= '0;
    end
  end

  // Valid strobe: high for exactly the cycle after this slice was written.
  always_ff @(posedge clk) begin
    if (rst) r_valid <= 1'b0;
    else     r_valid <= hit;
  end

  assign q       = r_data;
  assign q_valid = r_valid;

`ifdef DEMUX14_CNT_EN
  logic [CNT_W-1:0] r_cnt;

  // Hit counter: clear beats increment, and the count sticks at all-ones.
  always_ff @(posedge clk) begin
    if (rst || cnt_clr) begin
      r_cnt <= '0;
    end else if (hit && (r_cnt != '1)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign cnt = r_cnt;
`endif

endmodule

// File: rtl/de_mux14.sv
// de_mux14: registered 1-to-4 demultiplexer. {s1,s0} picks which of op0..op3
// receives the qualified input word one cycle later; op_valid is the matching
// one-hot strobe. HOLD_MODE selects zeroing or holding of unselected outputs.
// Optional feature macro: DEMUX14_CNT_EN adds per-output saturating hit
// counters cnt0..cnt3 and a synchronous clear input cnt_clr.
module de_mux14
  import de_mux14_pkg::*;
#(
  parameter int DATA_W    = 1,
  parameter int HOLD_MODE = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DATA_W-1:0]  in,
  input  logic               in_valid,
  input  logic               s0,
  input  logic               s1,
`ifdef DEMUX14_CNT_EN
  input  logic               cnt_clr,
  output logic [CNT_W-1:0]   cnt0,
  output logic [CNT_W-1:0]   cnt1,
  output logic [CNT_W-1:0]   cnt2,
  output logic [CNT_W-1:0]   cnt3,
`endif
  output logic [DATA_W-1:0]  op0,
  output logic [DATA_W-1:0]  op1,
  output logic [DATA_W-1:0]  op2,
  output logic [DATA_W-1:0]  op3,
  output logic [NUM_OUT-1:0] op_valid
);

  sel_e               w_sel;
  logic [NUM_OUT-1:0] w_hit;
  logic [DATA_W-1:0]  w_data [NUM_OUT];
`ifdef DEMUX14_CNT_EN
  logic [CNT_W-1:0]   w_cnt  [NUM_OUT];
`endif

  // Index decode: a hit is raised only for the selected output of a valid word.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_hit = '0;
    w_sel = sel_e'({s1, s0});
    if (in_valid) w_hit = sel_onehot(w_sel);
  end

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_chan
    de_mux14_chan #(
      .DATA_W    (DATA_W),
      .HOLD_MODE (HOLD_MODE)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .in      (in),
      .hit     (w_hit[g]),
`ifdef DEMUX14_CNT_EN
      .cnt_clr (cnt_clr),
      .cnt     (w_cnt[g]),
`endif
      .q       (w_data[g]),
      .q_valid (op_valid[g])
    );
  end

  assign op0 = w_data[SEL_OP0];
  assign op1 = w_data[SEL_OP1];
  assign op2 = w_data[SEL_OP2];
  assign op3 = w_data[SEL_OP3];

`ifdef DEMUX14_CNT_EN
  assign cnt0 = w_cnt[SEL_OP0];
  assign cnt1 = w_cnt[SEL_OP1];
  assign cnt2 = w_cnt[SEL_OP2];
  assign cnt3 = w_cnt[SEL_OP3];
`endif

endmodule

// File: tb/tb_de_mux14.sv
// Directed bench for de_mux14: a DATA_W=1/HOLD_MODE=0 instance (a_*) and a
// DATA_W=8/HOLD_MODE=1 instance (b_*) share clock and reset. Counter checks
// are present when DEMUX14_CNT_EN is defined.
module tb_de_mux14;

  logic clk = 1'b0;
  logic rst;
  logic cnt_clr;

  // Instance A: DATA_W=1, HOLD_MODE=0
  logic       a_in, a_in_valid, a_s0, a_s1;
  logic       a_op0, a_op1, a_op2, a_op3;
  logic [3:0] a_op_valid;
  logic [15:0] a_cnt0, a_cnt1, a_cnt2, a_cnt3;

  // Instance B: DATA_W=8, HOLD_MODE=1
  logic [7:0] b_in;
  logic       b_in_valid, b_s0, b_s1;
  logic [7:0] b_op0, b_op1, b_op2, b_op3;
  logic [3:0] b_op_valid;
  logic [15:0] b_cnt0, b_cnt1, b_cnt2, b_cnt3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  de_mux14 #(.DATA_W(1), .HOLD_MODE(0)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .in       (a_in),
    .in_valid (a_in_valid),
    .s0       (a_s0),
    .s1       (a_s1),
`ifdef DEMUX14_CNT_EN
    .cnt_clr  (cnt_clr),
    .cnt0     (a_cnt0),
    .cnt1     (a_cnt1),
    .cnt2     (a_cnt2),
    .cnt3     (a_cnt3),
`endif
    .op0      (a_op0),
    .op1      (a_op1),
    .op2      (a_op2),
    .op3      (a_op3),
    .op_valid (a_op_valid)
  );

  de_mux14 #(.DATA_W(8), .HOLD_MODE(1)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .in       (b_in),
    .in_valid (b_in_valid),
    .s0       (b_s0),
    .s1       (b_s1),
`ifdef DEMUX14_CNT_EN
    .cnt_clr  (cnt_clr),
    .cnt0     (b_cnt0),
    .cnt1     (b_cnt1),
    .cnt2     (b_cnt2),
    .cnt3     (b_cnt3),
`endif
    .op0      (b_op0),
    .op1      (b_op1),
    .op2      (b_op2),
    .op3      (b_op3),
    .op_valid (b_op_valid)
  );

`ifndef DEMUX14_CNT_EN
  assign {a_cnt0, a_cnt1, a_cnt2, a_cnt3} = '0;
  assign {b_cnt0, b_cnt1, b_cnt2, b_cnt3} = '0;
`endif

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Safety net: the run must always terminate.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: timeout observed, finish required");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; cnt_clr = 1'b0;
    a_in = 1'b1; a_in_valid = 1'b1; {a_s1, a_s0} = 2'b11;
    b_in = 8'h00; b_in_valid = 1'b0; {b_s1, b_s0} = 2'b00;

    // Reset held two cycles with an active word presented: must be ignored.
    tick();
    check("rst1 a_ops",   {a_op3, a_op2, a_op1, a_op0}, 4'b0000);
    check("rst1 a_valid", a_op_valid, 4'b0000);
    tick();
    check("rst2 a_ops",   {a_op3, a_op2, a_op1, a_op0}, 4'b0000);
    check("rst2 a_valid", a_op_valid, 4'b0000);
    check("rst2 b_ops",   {b_op3, b_op2, b_op1, b_op0}, 32'h0);
    check("rst2 b_valid", b_op_valid, 4'b0000);
    rst = 1'b0;

    // Full sweep: in=0 then in=1 for each select value.
    for (int k = 0; k < 4; k++) begin
      {a_s1, a_s0} = 2'(k);
      a_in_valid = 1'b1;
      a_in = 1'b0;
      tick();
      check($sformatf("sweep%0d in0 ops", k),   {a_op3, a_op2, a_op1, a_op0}, 4'b0000);
      check($sformatf("sweep%0d in0 valid", k), a_op_valid, 4'b0001 << k);
      a_in = 1'b1;
      tick();
      check($sformatf("sweep%0d in1 ops", k),   {a_op3, a_op2, a_op1, a_op0}, 4'b0001 << k);
      check($sformatf("sweep%0d in1 valid", k), a_op_valid, 4'b0001 << k);
    end

    // Latency: new selects must not show before the edge.
    {a_s1, a_s0} = 2'b00;
    #1;
    check("lat pre-edge ops", {a_op3, a_op2, a_op1, a_op0}, 4'b1000);
    tick();
    check("b2b sel00 ops", {a_op3, a_op2, a_op1, a_op0}, 4'b0001);
    {a_s1, a_s0} = 2'b01;
    tick();
    check("b2b sel01 ops", {a_op3, a_op2, a_op1, a_op0}, 4'b0010);
    {a_s1, a_s0} = 2'b10;
    tick();
    check("b2b sel10 ops", {a_op3, a_op2, a_op1, a_op0}, 4'b0100);
    {a_s1, a_s0} = 2'b11;
    tick();
    check("b2b sel11 ops", {a_op3, a_op2, a_op1, a_op0}, 4'b1000);
    check("b2b sel11 valid", a_op_valid, 4'b1000);

    // HOLD_MODE=0 with in_valid low: everything clears.
    a_in_valid = 1'b0;
    tick();
    check("a idle ops",   {a_op3, a_op2, a_op1, a_op0}, 4'b0000);
    check("a idle valid", a_op_valid, 4'b0000);

    // HOLD_MODE=1, DATA_W=8: routed values persist on unselected outputs.
    b_in_valid = 1'b1; b_in = 8'hA5; {b_s1, b_s0} = 2'b10;
    tick();
    check("hold A5 ops",   {b_op3, b_op2, b_op1, b_op0}, 32'h00A5_0000);
    check("hold A5 valid", b_op_valid, 4'b0100);
    b_in = 8'h3C; {b_s1, b_s0} = 2'b00;
    tick();
    check("hold 3C ops",   {b_op3, b_op2, b_op1, b_op0}, 32'h00A5_003C);
    check("hold 3C valid", b_op_valid, 4'b0001);
    b_in_valid = 1'b0; b_in = 8'h77; {b_s1, b_s0} = 2'b11;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("hold idle%0d ops", i),   {b_op3, b_op2, b_op1, b_op0}, 32'h00A5_003C);
      check($sformatf("hold idle%0d valid", i), b_op_valid, 4'b0000);
    end

    // Reset mid-stream discards the word presented in that cycle.
    rst = 1'b1; b_in_valid = 1'b1; b_in = 8'hFF; {b_s1, b_s0} = 2'b01;
    tick();
    check("midrst ops",   {b_op3, b_op2, b_op1, b_op0}, 32'h0);
    check("midrst valid", b_op_valid, 4'b0000);
    rst = 1'b0; b_in = 8'h11;
    tick();
    check("post-rst ops",   {b_op3, b_op2, b_op1, b_op0}, 32'h0000_1100);
    check("post-rst valid", b_op_valid, 4'b0010);

    // A zero word is still a legal routing.
    b_in = 8'h00;
    tick();
    check("zero word op1",   b_op1, 8'h00);
    check("zero word valid", b_op_valid, 4'b0010);

`ifdef DEMUX14_CNT_EN
    // Counters: two hits went to op1 since the mid-stream reset.
    check("cnt1 after rst", b_cnt1, 16'd2);
    b_in = 8'h5A; {b_s1, b_s0} = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    check("cnt3 five", b_cnt3, 16'd5);
    check("cnt0 zero", b_cnt0, 16'd0);
    check("cnt2 zero", b_cnt2, 16'd0);
    check("op3 routed", b_op3, 8'h5A);
    cnt_clr = 1'b1;
    tick();
    check("cnt_clr priority", b_cnt3, 16'd0);
    check("cnt_clr cnt1",     b_cnt1, 16'd0);
    cnt_clr = 1'b0;
    for (int i = 0; i < 65534; i++) tick();
    check("cnt3 preload", b_cnt3, 16'hFFFE);
    for (int i = 0; i < 3; i++) tick();
    check("cnt3 saturate", b_cnt3, 16'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_mux14.md
Name: de_mux14

Overview:
- Registered 1-to-4 demultiplexer.
- Routes a DATA_W-bit input word to one of four outputs, chosen by two select bits: s1 is the MSB, s0 the LSB.
- Used as a generic fan-out stage wherever one producer feeds one of four consumers.
- Outputs are registered: one-cycle latency, glitch-free towards downstream logic.

Parameters:
- DATA_W, 1, width of the data input and of each output.
- HOLD_MODE, 0, 0 = unselected outputs driven to zero; 1 = unselected outputs keep their last routed value.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- in  in  DATA_W  data word to route.
- in_valid  in  1  qualifies in; no routing when low.
- op0  out  DATA_W  output for select 00.
- op1  out  DATA_W  output for select 01.
- op2  out  DATA_W  output for select 10.
- op3  out  DATA_W  output for select 11.
- op_valid  out  4  one-hot strobe; bit k high means opk was written on the last edge.
- s0  in  1  select LSB.
- s1  in  1  select MSB.

Behaviour:
- Select index k = {s1,s0}: 0→op0, 1→op1, 2→op2, 3→op3.
- Reset (rst=1 at a rising edge):
  - op0..op3 = 0 and op_valid = 0 after that edge.
  - Reset overrides in_valid.
  - Reset mid-stream discards the word presented in that cycle.
- Latency: in/s0/s1/in_valid sampled at edge N appear on the outputs after edge N; exactly one cycle.
- in_valid=1:
  - opk <= in; op_valid <= one-hot(k).
  - Other outputs: HOLD_MODE=0 → 0; HOLD_MODE=1 → unchanged.
- in_valid=0:
  - op_valid <= 0.
  - HOLD_MODE=0 → all outputs 0.
  - HOLD_MODE=1 → all outputs unchanged.
- in=0 with in_valid=1 is a legal routing: op_valid still strobes and opk becomes 0.
- Select may change every cycle; no handshake or back-pressure, throughput one word per cycle.
- Combinational view (HOLD_MODE=0, DATA_W=1): opk = in & (index==k), delayed one cycle.
- No X propagation requirement beyond reset; selects are assumed driven.

Optional Feature:
- Macro DEMUX14_CNT_EN.
- Defined:
  - Adds four 16-bit outputs cnt0..cnt3 plus an input cnt_clr (1 bit, synchronous).
  - cntk increments on each edge where in_valid=1 and index==k.
  - Saturates at 16'hFFFF.
  - Cleared by rst or cnt_clr; cnt_clr has priority over the increment in the same cycle.
- Not defined: the counter ports and logic are absent; all other behaviour is identical.

Decomposition:
- Package de_mux14_pkg:
  - NUM_OUT=4, SEL_W=2, CNT_W=16.
  - Enum typedef sel_e {SEL_OP0, SEL_OP1, SEL_OP2, SEL_OP3}.
- Sub-module de_mux14_chan, instantiated four times via generate.
  - One output register slice: data register, valid flop, hold/zero logic and the optional counter.
  - Inputs: clk, rst, in, hit.
- Top level: index decode and the hit one-hot.

Test Plan:
- Reset: rst=1 for 2 cycles with in=1, in_valid=1, s1s0=11 → op0..op3=0, op_valid=0000 throughout.
- Full sweep (DATA_W=1, HOLD_MODE=0): for each (s1,s0) in 00,01,10,11, apply in=0 then in=1 with in_valid=1.
  - in=1 → only the matching opk=1 one cycle later.
  - in=0 → all outputs 0.
  - op_valid = 0001/0010/0100/1000 respectively.
- Latency and back-to-back: in=1 with s1s0 = 00,01,10,11 on consecutive cycles → op0..op3 pulse high on consecutive cycles, one cycle delayed.
- HOLD_MODE=1, DATA_W=8:
  - Route 8'hA5 to op2, then 8'h3C to op0 → op2 stays A5, op0=3C.
  - in_valid=0 for 3 cycles → values held, op_valid=0000.
- Reset mid-stream: assert rst in the same cycle as routing 8'hFF to op1 → op1=0 after the edge; normal routing resumes the cycle after rst drops.
- DEMUX14_CNT_EN:
  - 5 valid words to op3 → cnt3=5, other counters 0.
  - cnt_clr together with a valid word to op3 → cnt3=0.
  - Preload to 16'hFFFE, then 3 hits → cnt3=16'hFFFF.
